aquarium_mode_scheduler: RTL and testbench

Time-of-day scheduler that sits directly upstream of the AquariOS mode switcher and RGB control. It keeps a HH:MM:SS clock advanced by a one-second tick. It decodes the current aquarium mode (day, afternoon, evening, night) and generates feed requests at the four fixed feed times. It also produces a ramped brightness level that lighting and colour control consume.

---
 rtl/aquarium_mode_scheduler.sv | 176 +++++++++++++++++
 tb/tb_aquarium_mode_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aquarium_mode_scheduler.sv
// aquarium_mode_scheduler: HH:MM:SS time-of-day keeper driven by a one-second
// tick. It decodes the aquarium mode, raises feed requests at fixed times and
// ramps a brightness level toward the target for the registered mode.
module aquarium_mode_scheduler #(
  parameter int SEC_PER_MIN  = 60,
  parameter int RAMP_STEP    = 1,
  parameter int BRIGHT_DAY   = 200,
  parameter int BRIGHT_AFT   = 160,
  parameter int BRIGHT_EVE   = 100,
  parameter int BRIGHT_NIGHT = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       set_valid,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic       feed_ack,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [1:0] mode,
  output logic       mode_change,
  output logic [7:0] brightness,
  output logic       feed_req,
  output logic [1:0] feed_id,
  output logic       feed_overrun,
  output logic       set_err
);

  localparam int SW = $clog2(SEC_PER_MIN);
  localparam logic [SW-1:0] SEC_LAST = SW'(SEC_PER_MIN - 1);
  localparam logic [8:0]    STEP9    = 9'(RAMP_STEP);

  // Hour ranges: 6..11 day, 12..16 afternoon, 17..20 evening, else night.
  function automatic logic [1:0] mode_of(input logic [4:0] h);
    logic [1:0] m;
    if (h >= 5'd6 && h <= 5'd11)       m = 2'd0;
    else if (h >= 5'd12 && h <= 5'd16) m = 2'd1;
    else if (h >= 5'd17 && h <= 5'd20) m = 2'd2;
    else                               m = 2'd3;
    return m;
  endfunction

  function automatic logic [7:0] target_of(input logic [1:0] m);
    logic [7:0] t;
    case (m)
      2'd0:    t = 8'(BRIGHT_DAY);
      2'd1:    t = 8'(BRIGHT_AFT);
      2'd2:    t = 8'(BRIGHT_EVE);
      default: t = 8'(BRIGHT_NIGHT);
    endcase
    return t;
  endfunction

  logic [SW-1:0] sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic [1:0]    mode_q;
  logic          mode_change_q;
  logic [7:0]    bri_q, bri_d;
  logic          feed_req_q, feed_overrun_q;
  logic [1:0]    feed_id_q;
  logic          feed_evt_q, feed_evt_d;
  logic [1:0]    feed_slot_q, feed_slot_d;
  logic          set_err_q, set_err_d;
  logic          set_ok_s;

  assign set_ok_s = (set_hour <= 5'd23) && (set_min <= 6'd59);

  // Next time-of-day: a set request beats the tick; feed events only on a
  // natural minute rollover that lands on a feed time.
  always_comb begin
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    feed_evt_d  = 1'b0;
    feed_slot_d = 2'd0;
    set_err_d   = 1'b0;
    if (set_valid) begin
      if (set_ok_s) begin
        hour_d = set_hour;
        min_d  = set_min;
        sec_d  = '0;
      end else begin
        set_err_d = 1'b1;
      end
    end else if (sec_tick) begin
      if (sec_q == SEC_LAST) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          case (hour_d)
            5'd8:    begin feed_evt_d = 1'b1; feed_slot_d = 2'd0; end
            5'd12:   begin feed_evt_d = 1'b1; feed_slot_d = 2'd1; end
            5'd17:   begin feed_evt_d = 1'b1; feed_slot_d = 2'd2; end
            5'd21:   begin feed_evt_d = 1'b1; feed_slot_d = 2'd3; end
            default: begin feed_evt_d = 1'b0; feed_slot_d = 2'd0; end
          endcase
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + SW'(1);
      end
    end else begin
      sec_d = sec_q;
    end
  end

  // Brightness step toward the registered mode's target, 9-bit to avoid wrap.
  always_comb begin
    logic [8:0] b9, t9, up9;
    b9    = {1'b0, bri_q};
    t9    = {1'b0, target_of(mode_q)};
    up9   = b9 + STEP9;
    bri_d = bri_q;
    if (sec_tick) begin
      if (b9 < t9) begin
        bri_d = (up9 > t9) ? t9[7:0] : up9[7:0];
      end else if (b9 > t9) begin
        bri_d = (b9 >= t9 + STEP9) ? 8'(b9 - STEP9) : t9[7:0];
      end else begin
        bri_d = bri_q;
      end
    end else begin
      bri_d = bri_q;
    end
  end

  // State registers: time, mode pipeline, brightness, feed handshake, set error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sec_q          <= '0;
      min_q          <= 6'd0;
      hour_q         <= 5'd0;
      mode_q         <= 2'd3;
      mode_change_q  <= 1'b0;
      bri_q          <= 8'd0;
      feed_req_q     <= 1'b0;
      feed_id_q      <= 2'd0;
      feed_overrun_q <= 1'b0;
      feed_evt_q     <= 1'b0;
      feed_slot_q    <= 2'd0;
      set_err_q      <= 1'b0;
    end else begin
      sec_q         <= sec_d;
      min_q         <= min_d;
      hour_q        <= hour_d;
      mode_q        <= mode_of(hour_q);
      mode_change_q <= (mode_of(hour_q) != mode_q);
      bri_q         <= bri_d;
      feed_evt_q    <= feed_evt_d;
      feed_slot_q   <= feed_slot_d;
      set_err_q     <= set_err_d;
      if (feed_evt_q) begin
        if (feed_req_q && !feed_ack) feed_overrun_q <= 1'b1;
        feed_req_q <= 1'b1;
        feed_id_q  <= feed_slot_q;
      end else if (feed_ack) begin
        feed_req_q <= 1'b0;
      end
    end
  end

  assign hour         = hour_q;
  assign minute       = min_q;
  assign mode         = mode_q;
  assign mode_change  = mode_change_q;
  assign brightness   = bri_q;
  assign feed_req     = feed_req_q;
  assign feed_id      = feed_id_q;
  assign feed_overrun = feed_overrun_q;
  assign set_err      = set_err_q;

endmodule

// File: tb/tb_aquarium_mode_scheduler.sv
// Scoreboard bench for aquarium_mode_scheduler: a behavioural time-of-day model
// pushes the expected outputs for every clock edge; a monitor pops and compares.
module tb_aquarium_mode_scheduler;

  localparam int SPM  = 4;
  localparam int STEP = 1;

  logic       clock, reset, sec_tick, set_valid, feed_ack;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [4:0] o_hour;
  logic [5:0] o_minute;
  logic [1:0] o_mode, o_feed_id;
  logic       o_mode_change, o_feed_req, o_feed_overrun, o_set_err;
  logic [7:0] o_brightness;

  aquarium_mode_scheduler #(
    .SEC_PER_MIN(SPM), .RAMP_STEP(STEP), .BRIGHT_DAY(200), .BRIGHT_AFT(160),
    .BRIGHT_EVE(100), .BRIGHT_NIGHT(30)
  ) dut (
    .clock(clock), .reset(reset), .sec_tick(sec_tick), .set_valid(set_valid),
    .set_hour(set_hour), .set_min(set_min), .feed_ack(feed_ack),
    .hour(o_hour), .minute(o_minute), .mode(o_mode), .mode_change(o_mode_change),
    .brightness(o_brightness), .feed_req(o_feed_req), .feed_id(o_feed_id),
    .feed_overrun(o_feed_overrun), .set_err(o_set_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int hour, minute, mode, mc, bri, freq, fid, ovr, serr;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model state: minutes since midnight plus seconds.
  int tod, sec, m_mode, m_mc, m_bri, m_freq, m_fid, m_ovr, m_serr, pend;

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int mode_of_hour(input int h);
    if (h >= 6 && h < 12)  return 0;
    if (h >= 12 && h < 17) return 1;
    if (h >= 17 && h < 21) return 2;
    return 3;
  endfunction

  function automatic int target(input int md);
    int t [4] = '{200, 160, 100, 30};
    return t[md];
  endfunction

  function automatic int feed_slot(input int minutes);
    if (minutes == 8 * 60)  return 0;
    if (minutes == 12 * 60) return 1;
    if (minutes == 17 * 60) return 2;
    if (minutes == 21 * 60) return 3;
    return -1;
  endfunction

  function automatic void model_reset();
    tod = 0; sec = 0; m_mode = 3; m_mc = 0; m_bri = 0;
    m_freq = 0; m_fid = 0; m_ovr = 0; m_serr = 0; pend = -1;
  endfunction

  // One rising edge of behaviour, applied to the inputs held during the cycle.
  function automatic void model_step(input bit sv, input bit st, input int h,
                                     input int mi, input bit ack);
    int new_mode, t;
    new_mode = mode_of_hour(tod / 60);
    m_mc = (new_mode != m_mode) ? 1 : 0;
    if (st) begin
      t = target(m_mode);
      if (m_bri < t)      m_bri = (m_bri + STEP > t) ? t : m_bri + STEP;
      else if (m_bri > t) m_bri = (m_bri - STEP < t) ? t : m_bri - STEP;
    end
    m_mode = new_mode;
    if (pend >= 0) begin
      if (m_freq == 1 && !ack) m_ovr = 1;
      m_freq = 1;
      m_fid  = pend;
    end else if (ack) begin
      m_freq = 0;
    end
    pend = -1;
    m_serr = (sv && !(h <= 23 && mi <= 59)) ? 1 : 0;
    if (sv) begin
      if (h <= 23 && mi <= 59) begin
        tod = h * 60 + mi;
        sec = 0;
      end
    end else if (st) begin
      sec++;
      if (sec == SPM) begin
        sec  = 0;
        tod  = (tod + 1) % 1440;
        pend = feed_slot(tod);
      end
    end
  endfunction

  // Drive one cycle of inputs, let the edge happen, record the expectation.
  task automatic cyc(input bit sv, input bit st, input int h, input int mi, input bit ack);
    exp_t e;
    set_valid = sv; sec_tick = st; set_hour = 5'(h); set_min = 6'(mi); feed_ack = ack;
    @(posedge clock);
    if (reset) model_reset();
    else       model_step(sv, st, h, mi, ack);
    e.hour = tod / 60; e.minute = tod % 60; e.mode = m_mode; e.mc = m_mc;
    e.bri = m_bri; e.freq = m_freq; e.fid = m_fid; e.ovr = m_ovr; e.serr = m_serr;
    q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 0, 0, 1'b0);
      cyc(1'b0, 1'b0, 0, 0, 1'b0);
    end
  endtask

  task automatic set_time(input int h, input int mi);
    cyc(1'b1, 1'b0, h, mi, 1'b0);
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hour",         int'(o_hour),         e.hour);
        chk("minute",       int'(o_minute),       e.minute);
        chk("mode",         int'(o_mode),         e.mode);
        chk("mode_change",  int'(o_mode_change),  e.mc);
        chk("brightness",   int'(o_brightness),   e.bri);
        chk("feed_req",     int'(o_feed_req),     e.freq);
        chk("feed_id",      int'(o_feed_id),      e.fid);
        chk("feed_overrun", int'(o_feed_overrun), e.ovr);
        chk("set_err",      int'(o_set_err),      e.serr);
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    int hs [4] = '{7, 11, 16, 20};
    bit sv, st, ack;
    int h, mi;
    model_reset();
    reset = 1'b1; sec_tick = 1'b0; set_valid = 1'b0; feed_ack = 1'b0;
    set_hour = 5'd0; set_min = 6'd0;
    idle(2);
    reset = 1'b0;
    idle(3);

    // Mode rollover into day, then ramp up to the day target and hold.
    set_time(5, 59);
    ticks(4);
    idle(2);
    ticks(215);

    // Feed handshake, then loading a feed time directly.
    set_time(7, 59);
    ticks(4);
    idle(2);
    cyc(1'b0, 1'b0, 0, 0, 1'b1);
    idle(2);
    set_time(8, 0);
    idle(3);

    // Overrun, then an ack landing with the 17:00 event.
    set_time(7, 59);
    ticks(4);
    idle(2);
    set_time(11, 59);
    ticks(4);
    idle(2);
    set_time(16, 59);
    ticks(3);
    cyc(1'b0, 1'b1, 0, 0, 1'b0);
    cyc(1'b0, 1'b0, 0, 0, 1'b1);
    idle(3);

    // Rejected set, then set coinciding with a wrapping tick.
    cyc(1'b1, 1'b0, 24, 10, 1'b0);
    cyc(1'b1, 1'b0, 3, 60, 1'b0);
    idle(2);
    set_time(10, 29);
    ticks(3);
    cyc(1'b1, 1'b1, 10, 30, 1'b0);
    idle(1);
    ticks(4);

    // Day wrap stays in night mode.
    set_time(23, 59);
    ticks(4);
    idle(3);

    // Asynchronous reset mid-ramp with a feed pending.
    set_time(20, 59);
    ticks(4);
    ticks(3);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("async_hour",   int'(o_hour),         0);
    chk("async_minute", int'(o_minute),       0);
    chk("async_mode",   int'(o_mode),         3);
    chk("async_bri",    int'(o_brightness),   0);
    chk("async_feed",   int'(o_feed_req),     0);
    chk("async_ovr",    int'(o_feed_overrun), 0);
    model_reset();
    idle(2);
    reset = 1'b0;
    idle(3);

    // Randomized traffic, biased toward feed times.
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom % 3) == 0;
      ack = ($urandom % 8) == 0;
      sv  = ($urandom % 48) == 0;
      if ($urandom % 2 == 0) begin
        h  = hs[$urandom % 4];
        mi = 59;
      end else begin
        h  = $urandom_range(0, 25);
        mi = $urandom_range(0, 63);
      end
      cyc(sv, st, h, mi, ack);
    end
    idle(2);

    repeat (2) @(negedge clock);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
